// File: rtl/w4_weight_unpacker.sv
// w4_weight_unpacker: pops packed int4 weight words from a FWFT FIFO and emits LANES x int8 beats.
// Latency: pop in cycle T, beat 0 valid in T+1; one beat per cycle with no bubbles between words.
// Backpressure: out_ready low freezes hold/beat/out_data and blocks pops; fifo_rd_en is combinational.
// Optional feature: define W4_ZERO_POINT_EN to subtract an unsigned per-word zero point from each nibble.
module w4_weight_unpacker #(
   parameter int IN_WIDTH    = 32,
   parameter int LANES       = 4,
   parameter int GROUP_WORDS = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [IN_WIDTH-1:0]   fifo_data,
   input  logic                  fifo_valid,
   output logic                  fifo_rd_en,
`ifdef W4_ZERO_POINT_EN
   input  logic [3:0]            zero_point,
`endif
   output logic [8*LANES-1:0]    out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  busy
);

   localparam int BEATS  = IN_WIDTH / (4 * LANES);
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int CNT_W  = (GROUP_WORDS > 1) ? $clog2(GROUP_WORDS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(GROUP_WORDS - 1);

   typedef enum logic {ST_EMPTY, ST_FULL} state_t;

   state_t              state_q, state_d;
   logic [IN_WIDTH-1:0] hold_q, hold_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
`ifdef W4_ZERO_POINT_EN
   logic [3:0]          zp_q, zp_d;
   logic [4:0]          diff;
`endif

   logic                accept;
   logic                last_beat;
   logic                pop;
   logic [4*LANES-1:0]  beat_nibs;
   logic [3:0]          nib;

   assign out_valid  = (state_q == ST_FULL);
   assign busy       = out_valid;
   assign last_beat  = (beat_q == LAST_BEAT);
   assign accept     = out_valid & out_ready;
   // Reset gates the pop so a word is never lost from the FIFO while this block is being cleared.
   assign pop        = ~reset & fifo_valid & ((state_q == ST_EMPTY) | (accept & last_beat));
   assign fifo_rd_en = pop;
   assign out_last   = out_valid & last_beat & (word_cnt_q == LAST_WORD);

   // Next-state: refill on pop, advance beat on mid-word accept, drain to EMPTY when no refill.
   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      beat_d     = beat_q;
      word_cnt_d = word_cnt_q;
`ifdef W4_ZERO_POINT_EN
      zp_d       = zp_q;
`endif
      if (accept && last_beat) begin
         word_cnt_d = (word_cnt_q == LAST_WORD) ? '0 : word_cnt_q + CNT_W'(1);
      end
      if (pop) begin
         state_d = ST_FULL;
         hold_d  = fifo_data;
         beat_d  = '0;
`ifdef W4_ZERO_POINT_EN
         zp_d    = zero_point;
`endif
      end else if (accept) begin
         if (last_beat) begin
            state_d = ST_EMPTY;
         end else begin
            beat_d = beat_q + BEAT_W'(1);
         end
      end
   end

   // State registers; hold is cleared so out_data reads zero out of reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_EMPTY;
         hold_q     <= '0;
         beat_q     <= '0;
         word_cnt_q <= '0;
`ifdef W4_ZERO_POINT_EN
         zp_q       <= '0;
`endif
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         beat_q     <= beat_d;
         word_cnt_q <= word_cnt_d;
`ifdef W4_ZERO_POINT_EN
         zp_q       <= zp_d;
`endif
      end
   end

   // Current beat's nibbles come purely from registered hold/beat, so out_ready has no path to out_data.
   assign beat_nibs = hold_q[int'(beat_q) * 4 * LANES +: 4 * LANES];

   // Widen each nibble of the current beat to an 8-bit signed lane.
   always_comb begin
      out_data = '0;
      nib      = '0;
`ifdef W4_ZERO_POINT_EN
      diff     = '0;
`endif
      for (int l = 0; l < LANES; l++) begin
         nib = beat_nibs[4*l +: 4];
`ifdef W4_ZERO_POINT_EN
         diff = {1'b0, nib} - {1'b0, zp_q};
         out_data[8*l +: 8] = {{3{diff[4]}}, diff};
`else
         out_data[8*l +: 8] = {{4{nib[3]}}, nib};
`endif
      end
   end

endmodule

// File: tb/tb_w4_weight_unpacker.sv
// tb_w4_weight_unpacker: directed scenarios plus randomized traffic against a queue-based model.
// The model expands each popped word into its expected beats and group-last flags.
// One negedge process compares every cycle; directed steps add literal expectations.
module tb_w4_weight_unpacker;

   localparam int IN_WIDTH    = 32;
   localparam int LANES       = 4;
   localparam int GROUP_WORDS = 2;
   localparam int BEATS       = IN_WIDTH / (4 * LANES);
`ifdef W4_ZERO_POINT_EN
   localparam bit ZP_EN = 1'b1;
`else
   localparam bit ZP_EN = 1'b0;
`endif
   localparam logic [31:0] W0 = 32'h87654321;
   localparam logic [31:0] E0 = ZP_EN ? 32'hFCFBFAF9 : 32'h04030201;
   localparam logic [31:0] E1 = ZP_EN ? 32'h00FFFEFD : 32'hF8070605;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [31:0]   fifo_data = '0;
   logic          fifo_valid = 1'b0;
   logic          fifo_rd_en;
   logic [3:0]    zero_point = 4'd8;
   logic [31:0]   out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          out_last;
   logic          busy;

   typedef struct packed {
      logic [31:0] dat;
      logic        last;
   } beat_t;

   beat_t       exp_q[$];
   logic [31:0] fq[$];
   int          grp_cnt = 0;
   int          n_tests = 0;
   int          n_fail  = 0;
   bit          zp_random = 1'b0;
   beat_t       e_tmp;
   logic [31:0] w_tmp;
   logic        exp_rd;

   w4_weight_unpacker #(
      .IN_WIDTH(IN_WIDTH), .LANES(LANES), .GROUP_WORDS(GROUP_WORDS)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .fifo_data  (fifo_data),
      .fifo_valid (fifo_valid),
      .fifo_rd_en (fifo_rd_en),
`ifdef W4_ZERO_POINT_EN
      .zero_point (zero_point),
`endif
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected beat b of word w: lane l is nibble b*LANES+l, widened by plain integer arithmetic.
   function automatic logic [31:0] lane_word(input logic [31:0] w, input int b, input logic [3:0] zp);
      logic [31:0] r;
      int nib, v;
      r = '0;
      for (int l = 0; l < LANES; l++) begin
         nib = int'((w >> (4 * (b * LANES + l))) & 32'hF);
         if (ZP_EN) v = nib - int'(zp);
         else       v = (nib >= 8) ? nib - 16 : nib;
         r[8*l +: 8] = v[7:0];
      end
      return r;
   endfunction

   // Single compare process: checks outputs every cycle, then advances the model.
   always @(negedge clock) begin
      if (reset) begin
         check("rd_en_in_reset", fifo_rd_en, 1'b0);
         exp_q.delete();
         grp_cnt = 0;
      end else begin
         check("busy_eq_valid", busy, out_valid);
         check("out_valid", out_valid, exp_q.size() != 0);
         if (fifo_rd_en) check("rd_en_needs_valid", fifo_valid, 1'b1);
         exp_rd = fifo_valid && (exp_q.size() == 0 || (out_ready && exp_q.size() == 1));
         check("rd_en", fifo_rd_en, exp_rd);
         if (out_valid && exp_q.size() != 0) begin
            check("out_data", out_data, exp_q[0].dat);
            check("out_last", out_last, exp_q[0].last);
            if (out_ready) void'(exp_q.pop_front());
         end else begin
            check("out_last_idle", out_last, 1'b0);
         end
         if (fifo_rd_en) begin
            check("pop_nonempty", fq.size() != 0, 1'b1);
            if (fq.size() != 0) begin
               w_tmp = fq.pop_front();
               for (int b = 0; b < BEATS; b++) begin
                  e_tmp.dat  = lane_word(w_tmp, b, zero_point);
                  e_tmp.last = (b == BEATS - 1) && (grp_cnt == GROUP_WORDS - 1);
                  exp_q.push_back(e_tmp);
               end
               grp_cnt = (grp_cnt + 1) % GROUP_WORDS;
            end
         end
      end
   end

   // One cycle: drive inputs just after the rising edge, return at the falling edge for sampling.
   task automatic step(input bit rst, input bit rdy, input bit gate);
      @(posedge clock);
      #1;
      reset      = rst;
      out_ready  = rdy;
      fifo_valid = gate && (fq.size() != 0);
      fifo_data  = (fq.size() != 0) ? fq[0] : $urandom;
      zero_point = zp_random ? 4'($urandom_range(0, 15)) : 4'd8;
      @(negedge clock);
   endtask

   task automatic run_count(input int n, output int vcnt, output int rcnt, output int lcnt,
                            output int lstep, output int fvstep, output int lvstep);
      vcnt = 0; rcnt = 0; lcnt = 0; lstep = -1; fvstep = -1; lvstep = -1;
      for (int i = 1; i <= n; i++) begin
         step(1'b0, 1'b1, 1'b1);
         if (out_valid) begin
            vcnt++;
            if (fvstep < 0) fvstep = i;
            lvstep = i;
         end
         if (fifo_rd_en) rcnt++;
         if (out_last) begin
            lcnt++;
            lstep = i;
         end
      end
   endtask

   initial begin
      int vcnt, rcnt, lcnt, lstep, fvstep, lvstep;

      // Model pinned against hand-computed beats of the reference word.
      check("model_beat0", lane_word(W0, 0, 4'd8), E0);
      check("model_beat1", lane_word(W0, 1, 4'd8), E1);

      // Reset with a word waiting: no pop, all outputs at reset values.
      fq.push_back(W0);
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      check("rst_rd_en", fifo_rd_en, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 32'h0);
      check("rst_out_last", out_last, 1'b0);
      check("rst_busy", busy, 1'b0);

      // Single word: 1-cycle pop pulse, two beats on consecutive cycles, then idle.
      step(1'b0, 1'b1, 1'b1);
      check("w0_pop", fifo_rd_en, 1'b1);
      check("w0_valid_lat", out_valid, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      check("w0_beat0_valid", out_valid, 1'b1);
      check("w0_beat0", out_data, E0);
      check("w0_pop_pulse", fifo_rd_en, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      check("w0_beat1", out_data, E1);
      check("w0_beat1_last", out_last, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      check("w0_drained", out_valid, 1'b0);

      // Restart from EMPTY with 1-cycle latency.
      fq.push_back($urandom);
      step(1'b0, 1'b1, 1'b1);
      check("restart_pop", fifo_rd_en, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      check("restart_valid", out_valid, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);

      // Fresh group after reset: three words back to back.
      step(1'b1, 1'b1, 1'b0);
      repeat (3) fq.push_back($urandom);
      run_count(8, vcnt, rcnt, lcnt, lstep, fvstep, lvstep);
      check("b2b_valid_cnt", vcnt, 6);
      check("b2b_first_valid", fvstep, 2);
      check("b2b_contiguous", lvstep - fvstep, 5);
      check("b2b_pops", rcnt, 3);
      check("b2b_last_cnt", lcnt, 1);
      check("b2b_last_step", lstep, 5);

      // Backpressure during beat 0 with another word waiting in the FIFO.
      fq.push_back(W0);
      fq.push_back($urandom);
      step(1'b0, 1'b0, 1'b1);
      check("bp_pop", fifo_rd_en, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 1'b1);
         check("bp_hold_data", out_data, E0);
         check("bp_no_pop", fifo_rd_en, 1'b0);
      end
      step(1'b0, 1'b1, 1'b1);
      check("bp_accept_beat0", out_data, E0);
      step(1'b0, 1'b1, 1'b1);
      check("bp_beat1", out_data, E1);
      check("bp_refill", fifo_rd_en, 1'b1);
      repeat (3) step(1'b0, 1'b1, 1'b1);

      // Reset during beat 0: the rest of the word is dropped and the group count restarts.
      fq.push_back(W0);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      check("mid_beat0", out_data, E0);
      step(1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      check("mid_rst_valid", out_valid, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      check("mid_no_beat1", out_valid, 1'b0);
      repeat (2) fq.push_back($urandom);
      run_count(6, vcnt, rcnt, lcnt, lstep, fvstep, lvstep);
      check("mid_wordcnt_last", lstep, 5);
      check("mid_last_cnt", lcnt, 1);

      // Randomized traffic: FIFO gaps, backpressure, varying zero point, occasional resets.
      zp_random = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 2) == 0 && fq.size() < 6) fq.push_back($urandom);
         step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);
      end
      for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b1);
      check("drain_model_empty", exp_q.size(), 0);
      check("drain_fifo_empty", fq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
